// File: rtl/arm_scoreboard_hazard.sv
// Scoreboard hazard/forwarding unit beside ID: per-register write countdowns.
// Define HAZARD_FWD_EN to compile in the EXE forwarding path.
module arm_scoreboard_hazard #(
  parameter int NREG        = 16,
  parameter int DEPTH       = 3,
  parameter int CNT_W       = 3,
  parameter int STALL_CNT_W = 16,
  localparam int REG_W      = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_src1,
  input  logic [REG_W-1:0]       id_src2,
  input  logic                   id_two_src,
  input  logic                   id_wb_en,
  input  logic                   id_mem_read,
  input  logic [REG_W-1:0]       id_dest,
  output logic                   hazard,
  output logic [CNT_W-1:0]       fwd_sel1,
  output logic [CNT_W-1:0]       fwd_sel2,
  output logic [NREG-1:0]        busy_mask,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREG];
  logic             ld  [NREG];

  logic [CNT_W-1:0] c1;
  logic [CNT_W-1:0] c2;
  logic             h1;
  logic             h2;
  logic             issue;
  logic             stall_full;

  assign c1 = cnt[id_src1];
  assign c2 = cnt[id_src2];

`ifdef HAZARD_FWD_EN
  logic l1;
  logic l2;

  assign l1 = ld[id_src1];
  assign l2 = ld[id_src2];
  // Only a load still in EXE cannot be forwarded.
  assign h1 = l1 & (c1 == CNT_TOP);
  assign h2 = l2 & (c2 == CNT_TOP);
  assign fwd_sel1 = (c1 >= CNT_TWO && !h1) ? c1 : '0;
  assign fwd_sel2 = (c2 >= CNT_TWO && !h2) ? c2 : '0;
`else
  assign h1 = c1 >= CNT_TWO;
  assign h2 = c2 >= CNT_TWO;
  assign fwd_sel1 = '0;
  assign fwd_sel2 = '0;
`endif

  assign hazard = id_valid & ~flush & (h1 | (id_two_src & h2));
  assign issue  = id_valid & ~hazard & ~flush & ~freeze;
  assign stall_full = &stall_count;

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_mask[r] = cnt[r] != '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
        ld[r]  <= 1'b0;
      end
      stall_count <= '0;
    end else if (!freeze) begin
      for (int r = 0; r < NREG; r++) begin
        // A new producer overrides any older one on the same register.
        if (issue && id_wb_en && id_dest == REG_W'(r)) begin
          cnt[r] <= CNT_TOP;
          ld[r]  <= id_mem_read;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_ONE;
          ld[r]  <= ld[r] & (cnt[r] != CNT_ONE);
        end
      end
      if (hazard && !stall_full) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arm_scoreboard_hazard.sv
// Bench for arm_scoreboard_hazard: ready-time model plus directed vectors.
// Honours HAZARD_FWD_EN the same way the design does.
module tb_arm_scoreboard_hazard;

  localparam int NREG  = 16;
  localparam int DEPTH = 3;
  localparam int CNT_W = 3;
  localparam int SW    = 16;

  logic clk = 1'b0;
  logic rst;
  logic freeze, flush, id_valid, id_two_src, id_wb_en, id_mem_read;
  logic [3:0] id_src1, id_src2, id_dest;
  logic hazard;
  logic [CNT_W-1:0] fwd_sel1, fwd_sel2;
  logic [NREG-1:0] busy_mask;
  logic [SW-1:0] stall_count;

  arm_scoreboard_hazard #(
    .NREG(NREG), .DEPTH(DEPTH), .CNT_W(CNT_W), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_dest(id_dest),
    .hazard(hazard), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: a producer issued at tick T is readable DEPTH ticks later.
  int m_wr [NREG];
  bit m_ld [NREG];
  int m_tick;
  int m_stall;
  bit m_h;

  function automatic int rem(input int r);
    return (m_wr[r] + DEPTH > m_tick) ? m_wr[r] + DEPTH - m_tick : 0;
  endfunction

  function automatic bit src_haz(input int s);
`ifdef HAZARD_FWD_EN
    return m_ld[s] && rem(s) == DEPTH;
`else
    return rem(s) >= 2;
`endif
  endfunction

  function automatic bit exp_haz();
    return id_valid && !flush &&
      (src_haz(int'(id_src1)) || (id_two_src && src_haz(int'(id_src2))));
  endfunction

  function automatic int exp_fwd(input int s);
`ifdef HAZARD_FWD_EN
    return (rem(s) >= 2 && !src_haz(s)) ? rem(s) : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] b;
    b = '0;
    for (int r = 0; r < NREG; r++) b[r] = rem(r) != 0;
    return b;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tick = 0;
      m_stall = 0;
      for (int r = 0; r < NREG; r++) begin
        m_wr[r] = -100;
        m_ld[r] = 1'b0;
      end
    end else if (!freeze) begin
      m_h = exp_haz();
      m_tick++;
      if (m_h && m_stall != (1 << SW) - 1) m_stall++;
      if (id_valid && !m_h && !flush && id_wb_en) begin
        m_wr[id_dest] = m_tick;
        m_ld[id_dest] = id_mem_read;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("hazard", 32'(hazard), 32'(exp_haz()));
      chk("fwd_sel1", 32'(fwd_sel1), 32'(exp_fwd(int'(id_src1))));
      chk("fwd_sel2", 32'(fwd_sel2), 32'(exp_fwd(int'(id_src2))));
      chk("busy_mask", 32'(busy_mask), 32'(exp_busy()));
      chk("stall_count", 32'(stall_count), 32'(m_stall));
    end
  end

  task automatic drive(input bit v, input int s1, input int s2,
                       input bit two, input bit wb, input bit mr,
                       input int d, input bit frz = 0, input bit fl = 0);
    @(negedge clk);
    id_valid = v;
    id_src1 = 4'(s1);
    id_src2 = 4'(s2);
    id_two_src = two;
    id_wb_en = wb;
    id_mem_read = mr;
    id_dest = 4'(d);
    freeze = frz;
    flush = fl;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    freeze = 0; flush = 0; id_valid = 0; id_two_src = 0;
    id_wb_en = 0; id_mem_read = 0;
    id_src1 = 0; id_src2 = 0; id_dest = 0;
    cmp_en = 1;
    idle(2);
    chk("rst_busy", 32'(busy_mask), 0);
    chk("rst_stall", 32'(stall_count), 0);
    @(negedge clk) rst = 1'b1;
    idle(2);

    // ALU RAW on R2
    drive(1, 0, 0, 0, 1, 0, 2);
    drive(1, 2, 0, 0, 1, 0, 5);
`ifdef HAZARD_FWD_EN
    chk("raw_c1_haz", 32'(hazard), 0);
    chk("raw_c1_fwd", 32'(fwd_sel1), 3);
`else
    chk("raw_c1_haz", 32'(hazard), 1);
`endif
    drive(1, 2, 0, 0, 1, 0, 5);
`ifdef HAZARD_FWD_EN
    chk("raw_c2_fwd", 32'(fwd_sel1), 2);
`else
    chk("raw_c2_haz", 32'(hazard), 1);
`endif
    drive(1, 2, 0, 0, 1, 0, 5);
    chk("raw_c3_haz", 32'(hazard), 0);
    idle(1);
`ifdef HAZARD_FWD_EN
    chk("raw_stall", 32'(stall_count), 0);
`else
    chk("raw_stall", 32'(stall_count), 2);
`endif
    idle(4);

    // Load-use on R4 via src2
    drive(1, 0, 0, 0, 1, 1, 4);
    drive(1, 0, 4, 1, 1, 0, 6);
    chk("lu_c1_haz", 32'(hazard), 1);
    drive(1, 0, 4, 1, 1, 0, 6);
`ifdef HAZARD_FWD_EN
    chk("lu_c2_haz", 32'(hazard), 0);
    chk("lu_c2_fwd2", 32'(fwd_sel2), 2);
`else
    chk("lu_c2_haz", 32'(hazard), 1);
`endif
    drive(1, 0, 4, 1, 1, 0, 6);
    chk("lu_c3_haz", 32'(hazard), 0);
    idle(4);

    // Busy src2 ignored when two_src=0
    drive(1, 0, 0, 0, 1, 0, 7);
    drive(1, 0, 7, 0, 0, 0, 0);
    chk("one_src_haz", 32'(hazard), 0);
    idle(4);

    // Overwrite load R1 with ALU R1, then freeze
    drive(1, 0, 0, 0, 1, 1, 1);
    idle(1);
    drive(1, 0, 0, 0, 1, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    chk("ovw_busy1", 32'(busy_mask[1]), 1);
`ifdef HAZARD_FWD_EN
    chk("ovw_haz", 32'(hazard), 0);
    chk("ovw_fwd1", 32'(fwd_sel1), 3);
`else
    chk("ovw_haz", 32'(hazard), 1);
`endif
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_FWD_EN
    chk("frz_fwd1", 32'(fwd_sel1), 3);
`else
    chk("frz_haz", 32'(hazard), 1);
`endif
    idle(1);
`ifdef HAZARD_FWD_EN
    chk("frz_stall", 32'(stall_count), 1);
`else
    chk("frz_stall", 32'(stall_count), 4);
`endif
    idle(4);

    // Flush suppresses hazard and issue
    drive(1, 0, 0, 0, 1, 0, 11);
    drive(1, 11, 0, 0, 1, 0, 9, 0, 1);
    chk("flush_haz", 32'(hazard), 0);
    idle(1);
    chk("flush_no_entry", 32'(busy_mask[9]), 0);
    idle(4);

    // src1 == src2
    drive(1, 0, 0, 0, 1, 0, 10);
    idle(1);
    drive(1, 10, 10, 1, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    chk("same_fwd1", 32'(fwd_sel1), 2);
    chk("same_fwd2", 32'(fwd_sel2), 2);
`else
    chk("same_haz", 32'(hazard), 1);
`endif
    idle(1);

    // Mid-stream asynchronous reset
    drive(1, 0, 0, 0, 1, 0, 3);
    drive(1, 0, 0, 0, 1, 0, 8);
    @(negedge clk);
    rst = 1'b0;
    id_valid = 1; id_src1 = 4'd3; id_wb_en = 0;
    #1;
    chk("mid_rst_busy", 32'(busy_mask), 0);
    chk("mid_rst_haz", 32'(hazard), 0);
    chk("mid_rst_stall", 32'(stall_count), 0);
    idle(2);
    @(negedge clk) rst = 1'b1;
    idle(3);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
